// File: rtl/id_reg_file.sv
// ---------------------------------------------------------------------------
// id_reg_file
//
// Decode-stage register file for a 5-stage MIPS-style pipeline: 32 x 32-bit
// registers, two combinational read ports with same-cycle writeback bypass,
// one debug read port without bypass, and a counter of committed writes.
//
// Parameters
//   SP_INIT   reset value of register 29 ($sp)
//   ZERO_REG  index of the hardwired-zero register
//
// Ports
//   CLK          in   1   clock, all state changes on the rising edge
//   RESET        in   1   synchronous active-high reset
//   WB_RegWrite  in   1   writeback write enable
//   WB_RD        in   5   writeback destination index
//   WB_RD_DATA   in   32  writeback data
//   ID_RS        in   5   read port A index
//   ID_RT        in   5   read port B index
//   ID_RS_DATA   out  32  read port A data (combinational, bypassed)
//   ID_RT_DATA   out  32  read port B data (combinational, bypassed)
//   DBG_ADDR     in   5   debug read index
//   DBG_DATA     out  32  debug read data (stored content only)
//   WR_COUNT     out  32  number of committed writes (registered, wraps)
// ---------------------------------------------------------------------------
module id_reg_file #(
    parameter logic [31:0] SP_INIT  = 32'h7FFF_EFFC,
    parameter logic [4:0]  ZERO_REG = 5'd0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_RD,
    input  logic [31:0] WB_RD_DATA,
    input  logic [4:0]  ID_RS,
    input  logic [4:0]  ID_RT,
    output logic [31:0] ID_RS_DATA,
    output logic [31:0] ID_RT_DATA,
    input  logic [4:0]  DBG_ADDR,
    output logic [31:0] DBG_DATA,
    output logic [31:0] WR_COUNT
);

    logic [31:0] regs [32];
    logic [31:0] wr_count;

    logic commit_req;
    logic bypass_en;

    // A write only counts as a commit when it targets a real register; the
    // zero register silently swallows writes.
    assign commit_req = WB_RegWrite && (WB_RD != ZERO_REG);

    // Bypass is suppressed during reset because the pending write will be
    // discarded by the reset on this edge.
    assign bypass_en = commit_req && !RESET;

    // Reset wins over a simultaneous write, so the write is neither stored
    // nor counted on that edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 29) ? SP_INIT : 32'h0;
            end
            wr_count <= 32'h0;
        end else if (commit_req) begin
            regs[WB_RD] <= WB_RD_DATA;
            wr_count    <= wr_count + 32'd1;
        end
    end

    // Read port A: zero register first so it beats a matching bypass.
    always_comb begin
        ID_RS_DATA = regs[ID_RS];
        if (ID_RS == ZERO_REG) begin
            ID_RS_DATA = 32'h0;
        end else if (bypass_en && (WB_RD == ID_RS)) begin
            ID_RS_DATA = WB_RD_DATA;
        end
    end

    // Read port B: same rules as port A, evaluated independently.
    always_comb begin
        ID_RT_DATA = regs[ID_RT];
        if (ID_RT == ZERO_REG) begin
            ID_RT_DATA = 32'h0;
        end else if (bypass_en && (WB_RD == ID_RT)) begin
            ID_RT_DATA = WB_RD_DATA;
        end
    end

    // Debug port shows what is actually stored; the zero register still
    // reads as zero regardless of what reset put there.
    always_comb begin
        DBG_DATA = regs[DBG_ADDR];
        if (DBG_ADDR == ZERO_REG) begin
            DBG_DATA = 32'h0;
        end
    end

    assign WR_COUNT = wr_count;

endmodule

// File: tb/tb_id_reg_file.sv
module tb_id_reg_file;

    localparam logic [31:0] SP_INIT = 32'h7FFF_EFFC;

    logic        CLK;
    logic        RESET;
    logic        WB_RegWrite;
    logic [4:0]  WB_RD;
    logic [31:0] WB_RD_DATA;
    logic [4:0]  ID_RS;
    logic [4:0]  ID_RT;
    logic [31:0] ID_RS_DATA;
    logic [31:0] ID_RT_DATA;
    logic [4:0]  DBG_ADDR;
    logic [31:0] DBG_DATA;
    logic [31:0] WR_COUNT;

    int total;
    int bad;

    // Reference model: plain array of architectural register values and a
    // plain integer count of commits.
    logic [31:0] model_regs [32];
    logic [31:0] model_count;

    id_reg_file #(
        .SP_INIT (SP_INIT),
        .ZERO_REG(5'd0)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .WB_RegWrite(WB_RegWrite),
        .WB_RD      (WB_RD),
        .WB_RD_DATA (WB_RD_DATA),
        .ID_RS      (ID_RS),
        .ID_RT      (ID_RT),
        .ID_RS_DATA (ID_RS_DATA),
        .ID_RT_DATA (ID_RT_DATA),
        .DBG_ADDR   (DBG_ADDR),
        .DBG_DATA   (DBG_DATA),
        .WR_COUNT   (WR_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Value an ID read port should see right now: r0 is always zero, a live
    // non-reset write to the same register is visible immediately, otherwise
    // the architectural value.
    function automatic logic [31:0] expect_port(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (!RESET && WB_RegWrite && (WB_RD != 5'd0) && (WB_RD == idx)) return WB_RD_DATA;
        return model_regs[idx];
    endfunction

    function automatic logic [31:0] expect_dbg(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        return model_regs[idx];
    endfunction

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge, well away from the sampling edge.
    task automatic apply_stimulus(input logic rst, input logic we, input logic [4:0] rd,
                                  input logic [31:0] data, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] dbg);
        @(negedge CLK);
        RESET       = rst;
        WB_RegWrite = we;
        WB_RD       = rd;
        WB_RD_DATA  = data;
        ID_RS       = rs;
        ID_RT       = rt;
        DBG_ADDR    = dbg;
        #1;
    endtask

    task automatic check_output(input string tag);
        check_val({tag, ".rs"},    ID_RS_DATA, expect_port(ID_RS));
        check_val({tag, ".rt"},    ID_RT_DATA, expect_port(ID_RT));
        check_val({tag, ".dbg"},   DBG_DATA,   expect_dbg(DBG_ADDR));
        check_val({tag, ".count"}, WR_COUNT,   model_count);
    endtask

    // Advance through one rising edge and apply the architectural effect.
    task automatic clock_edge();
        @(posedge CLK);
        if (RESET) begin
            foreach (model_regs[i]) model_regs[i] = 32'h0;
            model_regs[29] = SP_INIT;
            model_count    = 32'h0;
        end else if (WB_RegWrite && WB_RD != 5'd0) begin
            model_regs[WB_RD] = WB_RD_DATA;
            model_count       = model_count + 32'd1;
        end
    endtask

    logic [4:0]  r_rd;
    logic [31:0] r_data;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;

    initial begin
        total = 0;
        bad   = 0;
        RESET = 1'b0; WB_RegWrite = 1'b0; WB_RD = '0; WB_RD_DATA = '0;
        ID_RS = '0; ID_RT = '0; DBG_ADDR = '0;
        foreach (model_regs[i]) model_regs[i] = 32'h0;
        model_count = 32'h0;

        // First reset, with junk on the write port; nothing checked before it.
        apply_stimulus(1'b1, 1'b1, 5'd7, 32'hAAAA_5555, 5'd29, 5'd5, 5'd29);
        clock_edge();

        // Reset values.
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd29, 5'd5, 5'd29);
        check_val("reset.sp",    ID_RS_DATA, 32'h7FFF_EFFC);
        check_val("reset.r5",    ID_RT_DATA, 32'h0);
        check_val("reset.count", WR_COUNT,   32'h0);
        check_output("reset");

        // Bypass on r8 while debug still shows the old stored value.
        apply_stimulus(1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd8, 5'd8);
        check_val("byp8.rs",     ID_RS_DATA, 32'hDEAD_BEEF);
        check_val("byp8.dbgold", DBG_DATA,   32'h0);
        check_output("byp8");
        clock_edge();
        apply_stimulus(1'b0, 1'b0, 5'd8, 32'h0, 5'd8, 5'd0, 5'd8);
        check_val("byp8.dbgnew", DBG_DATA, 32'hDEAD_BEEF);
        check_val("byp8.count",  WR_COUNT, 32'd1);
        check_output("post8");

        // Write to r0 is dropped and never bypassed.
        apply_stimulus(1'b0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
        check_val("r0.rs.pre", ID_RS_DATA, 32'h0);
        check_val("r0.rt.pre", ID_RT_DATA, 32'h0);
        clock_edge();
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        check_val("r0.rs.post", ID_RS_DATA, 32'h0);
        check_val("r0.count",   WR_COUNT,   32'd1);

        // Back-to-back writes to r3, last value wins.
        apply_stimulus(1'b0, 1'b1, 5'd3, 32'd1, 5'd3, 5'd3, 5'd3);
        check_output("r3a");
        clock_edge();
        apply_stimulus(1'b0, 1'b1, 5'd3, 32'd2, 5'd3, 5'd3, 5'd3);
        check_output("r3b");
        clock_edge();
        apply_stimulus(1'b0, 1'b0, 5'd3, 32'hFFFF_0000, 5'd0, 5'd3, 5'd3);
        check_val("r3.rt",    ID_RT_DATA, 32'd2);
        check_val("r3.count", WR_COUNT,   32'd3);

        // Reset beats a write to $sp; no bypass while reset is high.
        apply_stimulus(1'b1, 1'b1, 5'd29, 32'h0, 5'd29, 5'd8, 5'd29);
        check_val("rstw.sp.during", ID_RS_DATA, SP_INIT);
        clock_edge();
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd29, 5'd8, 5'd8);
        check_val("rstw.sp.after", ID_RS_DATA, SP_INIT);
        check_val("rstw.r8",       ID_RT_DATA, 32'h0);
        check_val("rstw.count",    WR_COUNT,   32'h0);

        // Randomized traffic with occasional reset, checked against the model.
        for (int n = 0; n < 300; n++) begin
            r_rd   = (($urandom % 2) == 0) ? 5'($urandom % 4) : 5'($urandom);
            r_data = $urandom;
            r_rs   = (($urandom % 3) == 0) ? r_rd : 5'($urandom);
            r_rt   = (($urandom % 3) == 0) ? r_rd : 5'($urandom);
            apply_stimulus((($urandom % 40) == 0), (($urandom % 4) != 0), r_rd, r_data,
                           r_rs, r_rt, 5'($urandom));
            check_output("rand");
            clock_edge();
        end

        // Counter wrap: preload all-ones, then one commit.
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        force dut.wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count;
        #1;
        model_count = 32'hFFFF_FFFF;
        check_val("wrap.pre", WR_COUNT, 32'hFFFF_FFFF);
        apply_stimulus(1'b0, 1'b1, 5'd9, 32'h0BAD_F00D, 5'd9, 5'd0, 5'd9);
        clock_edge();
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 5'd9);
        check_val("wrap.count", WR_COUNT, 32'h0);
        check_output("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

endmodule
